// File: rtl/hazard_unit_mc.sv
// Hazard unit: load-use bubbles, branch flushes, multi-cycle memory freeze.
// Optional perf counters are enabled by defining HAZARD_PERF_EN.
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_s3,
  input  logic [REG_AW-1:0] RegisterRt_s3,
  input  logic [REG_AW-1:0] RegisterRs,
  input  logic [REG_AW-1:0] RegisterRt,
  input  logic              mem_access_s4,
  input  logic              branch_s4,
  output logic              pc_stall,
  output logic              ID_stall,
  output logic              EX_stall,
  output logic              MEM_stall,
  output logic              IF_flush,
  output logic              ID_flush,
  output logic              EX_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  localparam int CntW = $clog2(MEM_LAT) + 1;
  localparam bit LongMem = (MEM_LAT > 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } stateE;

  stateE             state;
  logic [CntW-1:0]   cnt;
  logic              memTrigger;
  logic              freeze;
  logic              loadUse;

  // A new access only starts a freeze from IDLE; RELEASE ignores it.
  always_comb begin
    memTrigger = 1'b0;
    freeze     = 1'b0;
    if (state == IDLE) begin
      memTrigger = mem_access_s4 && LongMem;
    end
    freeze = memTrigger || (state == WAIT);
  end

  // Load in EX writing a register the ID instruction reads (r0 excluded).
  always_comb begin
    loadUse = 1'b0;
    if (MemRead_s3 && (RegisterRt_s3 != '0)) begin
      loadUse = (RegisterRt_s3 == RegisterRs) ||
                (RegisterRt_s3 == RegisterRt);
    end
  end

  // Memory-latency FSM: IDLE -> (WAIT) -> RELEASE -> IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memTrigger) begin
            if (MEM_LAT == 2) begin
              state <= RELEASE;
            end else begin
              state <= WAIT;
              cnt   <= CntW'(MEM_LAT - 2);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Priority: reset, freeze, branch flush, load-use bubble.
  always_comb begin
    pc_stall  = 1'b0;
    ID_stall  = 1'b0;
    EX_stall  = 1'b0;
    MEM_stall = 1'b0;
    IF_flush  = 1'b0;
    ID_flush  = 1'b0;
    EX_flush  = 1'b0;
    if (!rst_i) begin
      if (freeze) begin
        pc_stall  = 1'b1;
        ID_stall  = 1'b1;
        EX_stall  = 1'b1;
        MEM_stall = 1'b1;
      end else if (branch_s4) begin
        IF_flush = 1'b1;
        ID_flush = 1'b1;
        EX_flush = 1'b1;
      end else if (loadUse) begin
        pc_stall = 1'b1;
        ID_stall = 1'b1;
        ID_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating counts of stalled and flushed cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_stall && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (IF_flush && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc.
// Runs a MEM_LAT=3 and a MEM_LAT=1 instance side by side.
module tb_hazard_unit_mc;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       MemRead_s3;
  logic [4:0] RegisterRt_s3;
  logic [4:0] RegisterRs;
  logic [4:0] RegisterRt;
  logic       mem_access_s4;
  logic       branch_s4;

  logic pc3, ids3, exs3, mems3, iff3, idf3, exf3;
  logic pc1, ids1, exs1, mems1, iff1, idf1, exf1;
  logic [6:0] o3, o1;

  int nCmp = 0;
  int nErr = 0;

  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] FRZ   = 7'b1111000;
  localparam logic [6:0] LDU   = 7'b1100010;
  localparam logic [6:0] BRF   = 7'b0000111;

`ifdef HAZARD_PERF_EN
  logic [15:0] sc3, fc3, sc1, fc1;
`endif

  always #5 clk_i = ~clk_i;

  hazard_unit_mc #(.REG_AW(5), .MEM_LAT(3), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_s3(MemRead_s3), .RegisterRt_s3(RegisterRt_s3),
    .RegisterRs(RegisterRs), .RegisterRt(RegisterRt),
    .mem_access_s4(mem_access_s4), .branch_s4(branch_s4),
    .pc_stall(pc3), .ID_stall(ids3), .EX_stall(exs3),
    .MEM_stall(mems3), .IF_flush(iff3), .ID_flush(idf3),
    .EX_flush(exf3)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(sc3), .flush_cnt_o(fc3)
`endif
  );

  hazard_unit_mc #(.REG_AW(5), .MEM_LAT(1), .CNT_W(16)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_s3(MemRead_s3), .RegisterRt_s3(RegisterRt_s3),
    .RegisterRs(RegisterRs), .RegisterRt(RegisterRt),
    .mem_access_s4(mem_access_s4), .branch_s4(branch_s4),
    .pc_stall(pc1), .ID_stall(ids1), .EX_stall(exs1),
    .MEM_stall(mems1), .IF_flush(iff1), .ID_flush(idf1),
    .EX_flush(exf1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(sc1), .flush_cnt_o(fc1)
`endif
  );

  assign o3 = {pc3, ids3, exs3, mems3, iff3, idf3, exf3};
  assign o1 = {pc1, ids1, exs1, mems1, iff1, idf1, exf1};

  task automatic chk(input string tag, input logic [6:0] obs,
                     input logic [6:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkN(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    MemRead_s3    = 1'b0;
    RegisterRt_s3 = '0;
    RegisterRs    = '0;
    RegisterRt    = '0;
    mem_access_s4 = 1'b0;
    branch_s4     = 1'b0;
  endtask

  initial begin
    logic [6:0] pat [5];
    pat[0] = FRZ; pat[1] = FRZ; pat[2] = NONE;
    pat[3] = FRZ; pat[4] = FRZ;

    clr();
    rst_i = 1'b1;
    mem_access_s4 = 1'b1;
    branch_s4 = 1'b1;
    #3;
    chk("reset_forced0", o3, NONE);
    chk("reset_forced0_lat1", o1, NONE);
`ifdef HAZARD_PERF_EN
    chkN("reset_stallcnt", sc3, 16'd0);
`endif

    tick();
    clr();
    rst_i = 1'b0;
    #2;
    chk("idle_quiet", o3, NONE);

    // Freeze: access held three cycles.
    tick(); mem_access_s4 = 1'b1; #2;
    chk("frz_c0", o3, FRZ);
    chk("frz_c0_lat1", o1, NONE);
    tick(); #2;
    chk("frz_c1_wait", o3, FRZ);
    tick(); #2;
    chk("frz_c2_release", o3, NONE);
    tick(); mem_access_s4 = 1'b0; #2;
    chk("frz_back_idle", o3, NONE);

    // Load-use via rs.
    tick(); MemRead_s3 = 1'b1; RegisterRt_s3 = 5'd8;
    RegisterRs = 5'd8; #2;
    chk("ldu_rs", o3, LDU);
    chk("ldu_rs_lat1", o1, LDU);
    tick(); clr(); #2;
    chk("ldu_one_cycle", o3, NONE);
    tick(); MemRead_s3 = 1'b1; RegisterRt = 5'd17;
    RegisterRt_s3 = 5'd17; #2;
    chk("ldu_rt", o3, LDU);
    tick(); clr(); MemRead_s3 = 1'b1; #2;
    chk("ldu_r0_excluded", o3, NONE);
    tick(); clr(); RegisterRt_s3 = 5'd9; RegisterRs = 5'd9; #2;
    chk("no_memread", o3, NONE);
    tick(); clr(); MemRead_s3 = 1'b1; RegisterRt_s3 = 5'd9;
    RegisterRs = 5'd10; RegisterRt = 5'd11; #2;
    chk("ldu_nomatch", o3, NONE);

    // Branch beats load-use.
    tick(); clr(); MemRead_s3 = 1'b1; RegisterRt_s3 = 5'd8;
    RegisterRs = 5'd8; branch_s4 = 1'b1; #2;
    chk("br_over_ldu", o3, BRF);
    chk("br_over_ldu_lat1", o1, BRF);

    // Freeze masks branch and load-use; RELEASE ignores access.
    tick(); mem_access_s4 = 1'b1; #2;
    chk("frz_mask_c0", o3, FRZ);
    tick(); #2;
    chk("frz_mask_wait", o3, FRZ);
    tick(); #2;
    chk("release_branch", o3, BRF);
    tick(); clr(); #2;
    chk("after_mask_idle", o3, NONE);

    // Held access: MEM_LAT=1 never stalls, MEM_LAT=3 retriggers.
    for (int i = 0; i < 5; i++) begin
      tick(); mem_access_s4 = 1'b1; #2;
      chk($sformatf("lat1_hold%0d", i), o1, NONE);
      chk($sformatf("lat3_hold%0d", i), o3, pat[i]);
    end
    tick(); clr(); #2;
    chk("hold_end_idle", o3, NONE);

    // Reset mid-WAIT.
    tick(); mem_access_s4 = 1'b1; #2;
    chk("rst_pre_c0", o3, FRZ);
    tick();
    chk("rst_pre_wait", o3, FRZ);
    rst_i = 1'b1;
    #1;
    chk("rst_async0", o3, NONE);
`ifdef HAZARD_PERF_EN
    chkN("rst_stallcnt0", sc3, 16'd0);
    chkN("rst_flushcnt0", fc3, 16'd0);
`endif
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_refrz_c0", o3, FRZ);
`ifdef HAZARD_PERF_EN
    chkN("stallcnt_c0", sc3, 16'd0);
`endif
    tick(); #2;
    chk("rst_refrz_c1", o3, FRZ);
`ifdef HAZARD_PERF_EN
    chkN("stallcnt_c1", sc3, 16'd1);
`endif
    tick(); #2;
    chk("rst_refrz_rel", o3, NONE);
    tick(); clr(); #2;
    chk("rst_refrz_idle", o3, NONE);
`ifdef HAZARD_PERF_EN
    chkN("stallcnt_2", sc3, 16'd2);
    chkN("lat1_stallcnt", sc1, 16'd0);
    branch_s4 = 1'b1;
    tick(); clr(); #2;
    chkN("flushcnt_1", fc3, 16'd1);
    chkN("stallcnt_hold", sc3, 16'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule
